// File: rtl/reg_file_rd.sv
// reg_file_rd: 32x32 architectural register file with write-first bypass
// and a pending-write scoreboard that tells decode when to stall.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   wb_we, wb_rd, wb_data      write-back port from the write stage register
//   issue_en, issue_rd         decode issues a producer of issue_rd
//   flush                      clears every pending bit
//   rs1, rs2, rs1_used, ...    decode read indices and usage flags
//   rs1_data, rs2_data         combinational read data (bypassed)
//   rs1_busy, rs2_busy, stall  hazard outputs
//   pend_cnt                   number of set pending bits (registered)
module reg_file_rd #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int CNTW = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_we,
    input  logic [$clog2(NREG)-1:0] wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    issue_en,
    input  logic [$clog2(NREG)-1:0] issue_rd,
    input  logic                    flush,
    input  logic [$clog2(NREG)-1:0] rs1,
    input  logic [$clog2(NREG)-1:0] rs2,
    input  logic                    rs1_used,
    input  logic                    rs2_used,
    output logic [XLEN-1:0]         rs1_data,
    output logic [XLEN-1:0]         rs2_data,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    stall,
    output logic [CNTW-1:0]         pend_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [CNTW-1:0] cnt;

    logic wb_v;
    logic is_v;
    logic inc;
    logic dec;
    logic hit1;
    logic hit2;

    // x0 is never a real destination on either port
    assign wb_v = wb_we && (wb_rd != '0);
    assign is_v = issue_en && (issue_rd != '0);

    // Issue is applied after the write-back clear so a newer producer
    // on the same index keeps the bit set.
    always_comb begin
        pend_nxt = pend;
        if (flush) begin
            pend_nxt = '0;
        end else begin
            if (wb_v) pend_nxt[wb_rd] = 1'b0;
            if (is_v) pend_nxt[issue_rd] = 1'b1;
        end
    end

    // Counter tracks transitions only; a same-index clear+set is net 0.
    assign inc = is_v && !pend[issue_rd];
    assign dec = wb_v && pend[wb_rd]
              && !(is_v && (issue_rd == wb_rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_v) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            cnt  <= '0;
        end else begin
            pend <= pend_nxt;
            if (flush) cnt <= '0;
            else cnt <= cnt + CNTW'(inc) - CNTW'(dec);
        end
    end

    assign hit1 = wb_we && (wb_rd == rs1);
    assign hit2 = wb_we && (wb_rd == rs2);

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1 != '0) rs1_data = hit1 ? wb_data : regs[rs1];
        if (rs2 != '0) rs2_data = hit2 ? wb_data : regs[rs2];
    end

    // A write-back landing this cycle resolves the hazard immediately.
    assign rs1_busy = pend[rs1] && !hit1;
    assign rs2_busy = pend[rs2] && !hit2;
    assign stall    = (rs1_used && rs1_busy) || (rs2_used && rs2_busy);
    assign pend_cnt = cnt;

endmodule
